fp_normalize_round: RTL

Post-arithmetic normalize/round/pack stage of the SPI FPU datapath. It takes an unnormalized sign/exponent/magnitude result from the adder or multiplier core and locates the leading one using the `first_bit_position` leading-one detector. It then shifts, rounds to nearest-even and packs an IEEE-754 binary32 word with exception flags. It is a 2-stage valid/ready pipeline sitting between the arithmetic core and the SPI result register.

---
 rtl/fp_normalize_round.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fp_normalize_round.sv
// fp_normalize_round: normalizes an unnormalized sign/exponent/magnitude result,
// rounds it to nearest-even and packs an IEEE-754 binary32 word plus flags.
// Two-stage valid/ready pipeline: stage 1 normalizes, stage 2 rounds and packs.
module fp_normalize_round #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 30,
  parameter int EXP_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [WIDTH-1:0]        in_mant,
  input  logic                    in_nan,
  input  logic                    in_inf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic [3:0]              out_flags
);

  localparam int PW = $clog2(WIDTH);
  // Post-round exponent needs one bit more than the normalized one for the carry
  localparam int EW = EXP_W + 2;

  // Leading-one detector: position of the most significant set bit (0 for v == 0)
  function automatic logic [PW-1:0] first_bit_position(input logic [WIDTH-1:0] v);
    logic [PW-1:0] pos;
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) pos = PW'(i);
    end
    return pos;
  endfunction

  // Round-to-nearest-even on the 23-bit fraction; returns {carry, frac}
  function automatic logic [23:0] round_nearest_even(input logic [22:0] frac,
                                                     input logic guard,
                                                     input logic sticky);
    return {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
  endfunction

  // Exception priority and exponent saturation; returns {flags, result}
  function automatic logic [35:0] pack_result(input logic                 sign,
                                              input logic signed [EW-1:0] e,
                                              input logic [22:0]          frac,
                                              input logic                 inexact,
                                              input logic                 nan,
                                              input logic                 inf,
                                              input logic                 zero);
    if (nan)             return {4'b0000, 32'h7FC0_0000};
    if (inf)             return {4'b0000, sign, 8'hFF, 23'd0};
    if (zero)            return {4'b0001, sign, 31'd0};
    if (e >= EW'(255))   return {4'b1010, sign, 8'hFF, 23'd0};
    if (e <= EW'(0))     return {4'b0111, sign, 31'd0};
    return {2'b00, inexact, 1'b0, sign, e[7:0], frac};
  endfunction

  logic                    vld_p1, vld_p2;
  logic                    ld_p1, ld_p2;

  logic [PW-1:0]           lead_p0;
  logic [WIDTH-1:0]        norm_p0;
  logic signed [EXP_W:0]   exp_p0;

  logic                    sign_p1, nan_p1, inf_p1;
  logic signed [EXP_W:0]   exp_p1;
  logic [WIDTH-1:0]        norm_p1;

  logic [22:0]             frac_p1;
  logic                    guard_p1, sticky_p1, zero_p1;
  logic [23:0]             rnd_p1;
  logic signed [EW-1:0]    exp_rnd_p1;
  logic [35:0]             pack_p1;

  // Stage 2 advances when empty or draining; stage 1 when empty or stage 2 takes it
  assign ld_p2     = !vld_p2 || out_ready;
  assign ld_p1     = !vld_p1 || ld_p2;
  assign in_ready  = ld_p1;
  assign out_valid = vld_p2;

  // ---- stage 1: normalize (leading one to bit WIDTH-1, exponent adjust) ----
  always_comb begin
    lead_p0 = first_bit_position(in_mant);
    norm_p0 = in_mant << (PW'(WIDTH - 1) - lead_p0);
    exp_p0  = (EXP_W+1)'(in_exp)
            + $signed({{(EXP_W+1-PW){1'b0}}, lead_p0})
            - (EXP_W+1)'(FRAC);
  end

  // Stage 1 data capture on accept; valid bits gate it, so no reset needed
  always_ff @(posedge clk) begin
    if (ld_p1 && in_valid) begin
      sign_p1 <= in_sign;
      exp_p1  <= exp_p0;
      norm_p1 <= norm_p0;
      nan_p1  <= in_nan;
      inf_p1  <= in_inf;
    end
  end

  // ---- stage 2: round to nearest-even, handle exceptions, pack ----
  // A zero magnitude is the only case whose normalized top bit is clear
  always_comb begin
    frac_p1    = norm_p1[WIDTH-2 -: 23];
    guard_p1   = norm_p1[WIDTH-25];
    sticky_p1  = |norm_p1[WIDTH-26:0];
    zero_p1    = !norm_p1[WIDTH-1];
    rnd_p1     = round_nearest_even(frac_p1, guard_p1, sticky_p1);
    exp_rnd_p1 = EW'(exp_p1) + $signed({{(EW-1){1'b0}}, rnd_p1[23]});
    pack_p1    = pack_result(sign_p1, exp_rnd_p1, rnd_p1[22:0], guard_p1 | sticky_p1,
                             nan_p1, inf_p1, zero_p1);
  end

  // Pipeline valids and the output register; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      if (ld_p1) vld_p1 <= in_valid;
      if (ld_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) {out_flags, out_result} <= pack_p1;
      end
    end
  end

endmodule
